// File: rtl/img_pkg.sv
// Shared types and elaboration-time helpers for the image window address sequencer.
// Geometry math lives here so the top and any future consumers agree on it.
package img_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic int calc_wout(input int win, input int k, input int stride);
        return (win - k) / stride + 1;
    endfunction

    function automatic int calc_wbeats(input int k, input int ch);
        return k * k * ch;
    endfunction

    function automatic int calc_total(input int win, input int k, input int stride, input int ch);
        return calc_wout(win, k, stride) * calc_wout(win, k, stride) * calc_wbeats(k, ch);
    endfunction

    // Bits needed to hold 0..max; a zero-range counter still gets one bit.
    function automatic int cnt_width(input int max);
        return (max > 0) ? $clog2(max + 1) : 1;
    endfunction

    // Channel-planar, row-major image layout.
    function automatic int unsigned compose_addr(
        input int unsigned ch,
        input int unsigned orow,
        input int unsigned ocol,
        input int unsigned kr,
        input int unsigned kc,
        input int unsigned win,
        input int unsigned stride
    );
        return ch * win * win + (orow * stride + kr) * win + (ocol * stride + kc);
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo-(MAX+1) counter whose wrap output carries into the next counter of a chain.
module wrap_counter #(
    parameter int MAX = 1,
    parameter int W   = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    assign wrap = en && (cnt == W'(MAX));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/img_win_addr_gen.sv
// Walks a CH x WIN x WIN image in convolution-window order and drives the ROM address,
// with sideband flags delayed one extra cycle to line up with the ROM's registered data.
module img_win_addr_gen
    import img_pkg::*;
#(
    parameter int ADDR   = 18,
    parameter int CH     = 3,
    parameter int WIN    = 256,
    parameter int K      = 3,
    parameter int STRIDE = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            ready,
    output logic            busy,
    output logic            done,
    output logic [ADDR-1:0] address,
    output logic            pix_valid,
    output logic            win_first,
    output logic            win_last,
    output logic            img_last
);

    localparam int WOUT = calc_wout(WIN, K, STRIDE);
    localparam int M01  = (K > CH) ? K - 1 : CH - 1;
    localparam int MAXC = (M01 > WOUT - 1) ? M01 : WOUT - 1;
    localparam int DW   = cnt_width(MAXC);

    generate
        if ((longint'(CH) * WIN * WIN > (longint'(1) << ADDR)) || (K > WIN)) begin : g_param_err
            $error("img_win_addr_gen: image exceeds ROM address space or K > WIN");
        end
    endgenerate

    state_t          state_reg;
    logic            issue;
    logic            clr;
    logic [4:0]      en;
    logic [4:0]      wrap;
    logic [DW-1:0]   cnt [5];
    logic            is_first;
    logic            is_last;
    logic            is_imglast;
    logic            iss_reg;
    logic            first_reg;
    logic            last_reg;
    logic            imglast_reg;

    assign issue = (state_reg == RUN) && ready;
    assign clr   = (state_reg == IDLE) && start;
    assign busy  = (state_reg != IDLE);

    // Chain order, innermost first: kc, kr, ch, ocol, orow.
    assign en[0] = issue;
    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_cnt
            localparam int LMAX = (gi < 2) ? K - 1 : (gi == 2) ? CH - 1 : WOUT - 1;
            if (gi > 0) begin : g_carry
                assign en[gi] = wrap[gi-1];
            end
            wrap_counter #(
                .MAX (LMAX),
                .W   (DW)
            ) u_cnt (
                .clk  (clk),
                .rst  (rst),
                .clr  (clr),
                .en   (en[gi]),
                .cnt  (cnt[gi]),
                .wrap (wrap[gi])
            );
        end
    endgenerate

    assign is_first   = (cnt[0] == '0) && (cnt[1] == '0) && (cnt[2] == '0);
    assign is_last    = (cnt[0] == DW'(K - 1)) && (cnt[1] == DW'(K - 1)) && (cnt[2] == DW'(CH - 1));
    // The outermost wrap fires only when every counter sits at its max during an issue.
    assign is_imglast = wrap[4];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            address     <= '0;
            iss_reg     <= 1'b0;
            first_reg   <= 1'b0;
            last_reg    <= 1'b0;
            imglast_reg <= 1'b0;
            pix_valid   <= 1'b0;
            win_first   <= 1'b0;
            win_last    <= 1'b0;
            img_last    <= 1'b0;
            done        <= 1'b0;
        end else begin
            iss_reg     <= issue;
            first_reg   <= issue && is_first;
            last_reg    <= issue && is_last;
            imglast_reg <= is_imglast;
            if (issue) begin
                address <= ADDR'(compose_addr(32'(cnt[2]), 32'(cnt[4]), 32'(cnt[3]),
                                              32'(cnt[1]), 32'(cnt[0]), WIN, STRIDE));
            end
            pix_valid <= iss_reg;
            win_first <= first_reg;
            win_last  <= last_reg;
            img_last  <= imglast_reg;
            done      <= (state_reg == DRAIN);
            case (state_reg)
                IDLE:    if (start) state_reg <= RUN;
                RUN:     if (is_imglast) state_reg <= DRAIN;
                DRAIN:   state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_img_win_addr_gen.sv
// Directed bench for img_win_addr_gen on an 8x8x2 image, 3x3 kernel, stride 2.
module tb_img_win_addr_gen;

    localparam int ADDR   = 8;
    localparam int CH     = 2;
    localparam int WIN    = 8;
    localparam int K      = 3;
    localparam int STRIDE = 2;
    localparam int WBEATS = 18;
    localparam int TOTAL  = 162;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            ready;
    logic            busy;
    logic            done;
    logic [ADDR-1:0] address;
    logic            pix_valid;
    logic            win_first;
    logic            win_last;
    logic            img_last;

    img_win_addr_gen #(
        .ADDR   (ADDR),
        .CH     (CH),
        .WIN    (WIN),
        .K      (K),
        .STRIDE (STRIDE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .address   (address),
        .pix_valid (pix_valid),
        .win_first (win_first),
        .win_last  (win_last),
        .img_last  (img_last)
    );

    always #5 clk = ~clk;

    int         compared   = 0;
    int         mismatched = 0;
    int         q_addr[$];
    int         q_cyc[$];
    logic [2:0] q_flag[$];
    int         win00[18] = '{0, 1, 2, 8, 9, 10, 16, 17, 18, 64, 65, 66, 72, 73, 74, 80, 81, 82};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit pat(input int mode, input int c);
        if (mode == 1) return ((c - 1) % 4 == 0) || ((c - 1) % 4 == 3);
        return 1'b1;
    endfunction

    function automatic int exp_addr(input int k);
        int kc, kr, ch, ocol, orow;
        kc   = k % K;
        kr   = (k / K) % K;
        ch   = (k / (K * K)) % CH;
        ocol = (k / WBEATS) % 3;
        orow = k / (WBEATS * 3);
        return ch * WIN * WIN + (orow * STRIDE + kr) * WIN + ocol * STRIDE + kc;
    endfunction

    // mode 0: ready=1; mode 1: ready 1,0,0,1 repeating; mode 2: ready=1 with stray start pulses.
    task automatic run_scan(input int mode, input int rst_at, output int nbeats);
        int          c;
        bit          fin;
        logic [31:0] prev_addr;
        q_addr.delete();
        q_cyc.delete();
        q_flag.delete();
        start = 1'b1;
        ready = 1'b1;
        step();
        start = 1'b0;
        check("start_busy", 32'(busy), 1);
        prev_addr = 32'(address);
        c = 1;
        fin = 1'b0;
        while (!fin && c < 1000) begin
            ready = pat(mode, c);
            start = (mode == 2) && (c % 37 == 5);
            step();
            if (pix_valid === 1'b1) begin
                q_addr.push_back(int'(prev_addr));
                q_cyc.push_back(c);
                q_flag.push_back({win_first, win_last, img_last});
            end
            if (done === 1'b1) begin
                fin = 1'b1;
                check("done_pix_valid", 32'(pix_valid), 1);
                check("done_img_last", 32'(img_last), 1);
                check("done_busy", 32'(busy), 0);
            end
            if (rst_at > 0 && q_addr.size() == rst_at && !fin) begin
                rst   = 1'b1;
                start = 1'b0;
                step();
                rst = 1'b0;
                check("rst_flags", 32'({busy, done, pix_valid, win_first, win_last, img_last}), 0);
                check("rst_address", 32'(address), 0);
                for (int i = 0; i < 4; i++) begin
                    ready = 1'b1;
                    step();
                    check("rst_quiet", 32'({pix_valid, busy}), 0);
                end
                fin = 1'b1;
            end
            prev_addr = 32'(address);
            c++;
        end
        start = 1'b0;
        check("scan_finished", 32'(fin), 1);
        nbeats = q_addr.size();
    endtask

    task automatic verify_beats(input int mode, input int n);
        logic [2:0] ef;
        int         j;
        for (int k = 0; k < n; k++) begin
            ef = {k % WBEATS == 0, k % WBEATS == WBEATS - 1, k == TOTAL - 1};
            check($sformatf("addr[%0d]", k), q_addr[k], exp_addr(k));
            check($sformatf("flags[%0d]", k), 32'(q_flag[k]), 32'(ef));
        end
        j = 0;
        for (int c = 1; j < n && c < 2000; c++) begin
            if (pat(mode, c)) begin
                check($sformatf("cycle[%0d]", j), q_cyc[j], c + 1);
                j++;
            end
        end
    endtask

    initial begin
        int n;
        rst   = 1'b1;
        start = 1'b0;
        ready = 1'b0;
        repeat (3) step();
        check("reset_flags", 32'({busy, done, pix_valid, win_first, win_last, img_last}), 0);
        check("reset_address", 32'(address), 0);
        rst = 1'b0;
        step();
        check("idle_busy", 32'(busy), 0);

        run_scan(0, 0, n);
        $display("scan 1 (ready high): %0d beats, last address %0d", n, q_addr[n-1]);
        check("scan1_beats", n, TOTAL);
        for (int i = 0; i < 18; i++) check($sformatf("win00[%0d]", i), q_addr[i], win00[i]);
        check("win01_start", q_addr[18], 2);
        check("win10_start", q_addr[54], 16);
        check("last_addr", q_addr[161], 118);
        verify_beats(0, n);

        // Started in the very cycle scan 1 reported done.
        run_scan(1, 0, n);
        $display("scan 2 (backpressure, start on done): %0d beats", n);
        check("scan2_beats", n, TOTAL);
        check("scan2_first_addr", q_addr[0], 0);
        verify_beats(1, n);

        run_scan(2, 0, n);
        $display("scan 3 (start pulses while busy): %0d beats", n);
        check("scan3_beats", n, TOTAL);
        verify_beats(2, n);

        run_scan(0, 50, n);
        $display("scan 4 (reset at beat 50): %0d beats", n);
        check("scan4_beats", n, 50);
        verify_beats(0, n);

        run_scan(0, 0, n);
        $display("scan 5 (replay after reset): %0d beats", n);
        check("scan5_beats", n, TOTAL);
        check("scan5_first_addr", q_addr[0], 0);
        verify_beats(0, n);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/img_win_addr_gen.md
Name: img_win_addr_gen

Overview:
Upstream address sequencer for the first-layer image ROM. It walks the stored CH x WIN x WIN image in convolution-window order (K x K kernel, stride STRIDE, no padding) and drives the ROM address input. It also produces sideband flags (valid, first-of-window, last-of-window, last-of-image) delayed to line up with the ROM's registered data output. The first-layer MAC array consumes the ROM data together with these flags.

Parameters:
ADDR, 18, ROM address width
CH, 3, input channels
WIN, 256, image width = height, in pixels
K, 3, kernel size
STRIDE, 2, convolution stride

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  single-cycle request to scan the whole image; ignored while busy
ready  in  1  downstream can accept an issue this cycle
busy  out  1  scan in progress
done  out  1  one-cycle pulse, coincident with the final pix_valid
address  out  ADDR  ROM address, registered
pix_valid  out  1  ROM img_out holds a valid window element this cycle
win_first  out  1  with pix_valid: first element of a window
win_last  out  1  with pix_valid: last element of a window
img_last  out  1  with pix_valid: last element of the last window

Behaviour:
- Derived constants:
  - WOUT = (WIN-K)/STRIDE + 1
  - WBEATS = K*K*CH
  - TOTAL = WOUT*WOUT*WBEATS
- Elaboration error if CH*WIN*WIN > 2**ADDR or K > WIN.
- Memory layout: addr = ch*WIN*WIN + row*WIN + col.
  - row = orow*STRIDE + kr
  - col = ocol*STRIDE + kc
- Counter nesting, innermost first: kc, kr, ch, ocol, orow.
  - Each counter wraps to 0 and carries to the next.
  - All counters reset to 0.
- States: IDLE, RUN, DRAIN.
  - IDLE: start=1 -> RUN; counters cleared.
  - RUN, ready=1 (issue edge): address <= addr(counters); iss <= 1; counters advance.
    - On the issue of the last beat (all counters at max): -> DRAIN.
  - RUN, ready=0: counters and address hold; iss <= 0.
  - DRAIN: -> IDLE after one cycle. ready is ignored.
- Flag alignment:
  - iss, first, last and imglast are registered alongside address.
  - They are registered once more to form pix_valid, win_first, win_last, img_last.
  - This delay matches the ROM's one-cycle registered read.
- Latency:
  - start sampled at edge E0.
  - First issue at edge E1 if ready=1; address=0 after E1.
  - pix_valid=1 and win_first=1 after E2.
- done = registered (DRAIN state). It is high in the same cycle as the final pix_valid/img_last; busy is 0 that cycle.
- busy = (state != IDLE).
- Consumer must accept every pix_valid beat; backpressure acts only through ready, one cycle ahead.
- Reset values:
  - busy=0, done=0, address=0.
  - pix_valid, win_first, win_last, img_last = 0.
  - State IDLE.
- rst mid-scan: everything returns to the reset values on the next edge; no further pix_valid.
- start during RUN/DRAIN: ignored.
- start in the same cycle as done: accepted; new scan begins.
- ready toggling every cycle: no beats lost or duplicated; beat order is unchanged.

Decomposition:
- Package img_pkg:
  - state enum (IDLE/RUN/DRAIN)
  - functions/constants for WOUT, WBEATS, TOTAL
  - address-composition function
- Sub-module wrap_counter (parameter MAX):
  - inputs clk, rst, clr, en; outputs cnt, wrap = en && cnt==MAX.
  - Instantiated five times, chained via wrap.

Test Plan (WIN=8, CH=2, K=3, STRIDE=2, so WOUT=3, WBEATS=18, TOTAL=162, ready=1 unless stated):
- Window (0,0): start -> first 18 addresses 0,1,2,8,9,10,16,17,18,64,65,66,72,73,74,80,81,82; win_first on beat 0, win_last on beat 17.
- Window (0,1) starts at address 2; window (1,0) starts at address 16.
- Full scan: exactly 162 pix_valid beats; last address 118; img_last and done on the same cycle; busy low that cycle.
- Backpressure: ready = 1,0,0,1,... pattern -> address sequence identical to the ready=1 run; pix_valid gaps exactly one cycle after each ready=0.
- rst asserted at beat 50 -> next cycle all outputs 0; a new start replays from address 0.
- start pulsed during busy -> ignored, beat count stays 162. start coincident with done -> second scan begins; first address after the next edge is 0.
